alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one 32-bit logic/arithmetic unit between two requesters (e.g. fetch-side and execute-side clients).
//  Round-robin arbitration with a valid/ready handshake on each request and response channel.
//  Operands are captured, the result is registered, and the result returns on the winner's response channel.
//  Sits between client FSMs and the bitwise gate-level datapath (32 parallel 2-input gates per op).
// PARAMETERS
//  WIDTH     32   operand/result width in bits
//  OP_W      3    opcode width
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  req_valid    in   2          bit i: requester i presents an op
//  req_ready    out  2          bit i: op accepted this cycle (one-hot or zero)
//  req_op       in   2*OP_W     [i*OP_W +: OP_W] opcode of requester i
//  req_a        in   2*WIDTH    [i*WIDTH +: WIDTH] operand A of requester i
//  req_b        in   2*WIDTH    [i*WIDTH +: WIDTH] operand B of requester i
//  rsp_valid    out  2          bit i: result for requester i available
//  rsp_ready    in   2          bit i: requester i consumes the result
//  rsp_result   out  WIDTH      registered result (shared bus, qualified by rsp_valid)
//  rsp_zero     out  1          rsp_result == 0
//  rsp_err      out  1          opcode was illegal
// BEHAVIOUR
//  Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6 SLT (signed, result 0/1), 7 illegal -> result 0, err=1.
//  ADD/SUB wrap modulo 2^WIDTH; carry-out and overflow are discarded.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any req_valid, grant = round-robin winner; req_ready[grant] = 1 combinationally this cycle;
//         capture op/a/b/grant into registers; go to EXEC. No valid: stay in IDLE, req_ready = 0.
//   EXEC: compute from captured regs; register result/zero/err; go to RESP. req_ready = 0.
//   RESP: rsp_valid[grant] = 1, other bit 0; result stable. On rsp_ready[grant] -> IDLE and update the pointer.
//         rsp_ready on the non-granted bit is ignored.
//  Round-robin: pointer = last served requester. Both valid -> serve !pointer. Only one valid -> serve it.
//   Pointer updates only at response completion.
//  Latency: accept at cycle T -> rsp_valid at T+2. Peak throughput 1 op / 3 cycles (rsp_ready held high).
//  req_ready is asserted only in IDLE. A requester deasserting valid before ready is tolerated (no capture).
//  Request inputs are not sampled outside the IDLE accept cycle; changes during EXEC/RESP have no effect.
//  Reset (async, any state): state = IDLE, pointer = 1 (requester 0 wins first tie), req_ready = 0,
//   rsp_valid = 0, rsp_result = 0, rsp_zero = 0, rsp_err = 0.
//   An in-flight op is dropped; no response is issued after reset.
//  rsp_zero/rsp_err are valid only while rsp_valid != 0; they are held at their last value otherwise.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_AND..OP_ILL), state enum encoding (IDLE=0, EXEC=1, RESP=2).
//  Sub-module alu_core (combinational: op, a, b -> result, err) instantiated once.
//   alu_core is built from the existing per-bit 32-wide gate modules plus an adder.
//  Top level holds the FSM, arbiter pointer, capture regs and output regs.
// TESTING
//  1 Reset then req_valid=01, op=OR, a=0xF0F0_0000, b=0x0000_0F0F -> ready[0] at T; rsp_valid=01 at T+2; result 0xF0F0_0F0F.
//  2 Both valid every cycle, rsp_ready=11 -> grants alternate 0,1,0,1; each response returned to the matching bit.
//  3 ADD 0xFFFF_FFFF + 1 -> result 0, rsp_zero=1; SLT a=0x8000_0000, b=0 -> result 1.
//  4 op=7 -> result 0, rsp_err=1; the next legal op clears err.
//  5 Hold rsp_ready=0 for 5 cycles in RESP with new req_valid on the other port
//    -> result stable, req_ready stays 0; ready is granted only after the handshake.
//  6 Assert rst_n=0 during EXEC -> all outputs 0 immediately; no rsp_valid after release; requester 0 wins the next tie.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the ALU arbiter and its core
package alu_pkg;
   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_NOR = 3'd3;
   localparam logic [2:0] OP_ADD = 3'd4;
   localparam logic [2:0] OP_SUB = 3'd5;
   localparam logic [2:0] OP_SLT = 3'd6;
   localparam logic [2:0] OP_ILL = 3'd7;
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational logic/arithmetic unit (op, a, b -> result, err)
//   op_i     opcode
//   a_i/b_i  operands
//   result_o result; 0 for the illegal opcode
//   err_o    opcode was illegal
module alu_core import alu_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3
) (
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             err_o
);
   always_comb begin
      result_o = '0;
      err_o    = 1'b0;
      case (op_i)
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_NOR:  result_o = ~(a_i | b_i);
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         default: err_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one registered ALU between two requesters
//   clk, rst_n     clock, async active-low reset
//   req_valid/ready request handshake per requester (ready one-hot or zero)
//   req_op/a/b     packed per-requester opcode and operands
//   rsp_valid/ready response handshake per requester
//   rsp_result     registered result, qualified by rsp_valid
//   rsp_zero/err   result is zero / opcode was illegal
module alu_share_arbiter import alu_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*OP_W-1:0]  req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic               rsp_zero,
   output logic               rsp_err
);
   state_t            state_q, state_d;
   logic              ptr_q, grant_q, win, accept, done, alu_err, zero_q, err_q;
   logic [OP_W-1:0]   op_q;
   logic [WIDTH-1:0]  a_q, b_q, result_q, alu_result;
   // ptr_q holds the last served requester; a tie goes to the other one
   assign win    = &req_valid ? ~ptr_q : req_valid[1];
   assign accept = (state_q == IDLE) && |req_valid;
   assign done   = (state_q == RESP) && rsp_ready[grant_q];
   alu_core #(.WIDTH(WIDTH), .OP_W(OP_W)) u_core (
      .op_i(op_q), .a_i(a_q), .b_i(b_q), .result_o(alu_result), .err_o(alu_err)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb begin
      state_d = (state_q == IDLE) ? (|req_valid ? EXEC : IDLE) :
                (state_q == EXEC) ? RESP :
                (state_q == RESP) ? (rsp_ready[grant_q] ? IDLE : RESP) : IDLE;
   end
   // ready is gated by rst_n so a valid held through reset is never acknowledged
   always_comb begin
      req_ready = (accept && rst_n) ? (win ? 2'b10 : 2'b01) : 2'b00;
      rsp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
   end
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp_err    = err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= 1'b1;
         grant_q  <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            grant_q <= win;
            op_q    <= win ? req_op[OP_W +: OP_W] : req_op[0 +: OP_W];
            a_q     <= win ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
            b_q     <= win ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
         end
         if (state_q == EXEC) begin
            result_q <= alu_result;
            zero_q   <= (alu_result == '0);
            err_q    <= alu_err;
         end
         if (done) ptr_q <= grant_q;
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed table-driven and sequence checks for alu_share_arbiter
module tb_alu_share_arbiter;
   import alu_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0, rsp_ready = '0, req_ready, rsp_valid;
   logic [5:0]  req_op = '0;
   logic [63:0] req_a = '0, req_b = '0;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_err;
   int          pass_cnt = 0, total_cnt = 0;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, r;
      logic        z, e;
   } vec_t;
   vec_t vt[14];
   alu_share_arbiter #(.WIDTH(32), .OP_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic set_req(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin
         req_op[2:0] = op; req_a[31:0] = a; req_b[31:0] = b;
      end else begin
         req_op[5:3] = op; req_a[63:32] = a; req_b[63:32] = b;
      end
   endtask
   task automatic run_op(input int p, input vec_t v);
      logic [1:0] oh;
      oh = (p == 0) ? 2'b01 : 2'b10;
      set_req(p, v.op, v.a, v.b);
      req_valid = oh;
      #4 chk("accept_ready", 32'(req_ready), 32'(oh));
      tick;
      req_valid = 2'b00;
      #4 chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
      tick;
      #4 chk("rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("rsp_result", rsp_result, v.r);
      chk("rsp_zero", 32'(rsp_zero), 32'(v.z));
      chk("rsp_err", 32'(rsp_err), 32'(v.e));
      rsp_ready = oh;
      tick;
      rsp_ready = 2'b00;
   endtask
   initial begin
      vt[0]  = '{OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0};
      vt[1]  = '{OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0};
      vt[2]  = '{OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0};
      vt[3]  = '{OP_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vt[4]  = '{OP_NOR, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      vt[5]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
      vt[6]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
      vt[7]  = '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vt[8]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
      vt[9]  = '{OP_SLT, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0};
      vt[10] = '{OP_SLT, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
      vt[11] = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
      vt[12] = '{OP_ILL, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b1};
      vt[13] = '{OP_OR,  32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0};
      #3;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      chk("rst_zero", 32'(rsp_zero), 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      tick;
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) run_op(i % 2, vt[i]);
      // response stall with a competing request on the other port
      set_req(0, OP_ADD, 32'd10, 32'd20);
      req_valid = 2'b01;
      #4 chk("stall_accept", 32'(req_ready), 32'h1);
      tick;
      req_valid = 2'b10;
      set_req(1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
      rsp_ready = 2'b10;
      #4 chk("stall_exec_ready", 32'(req_ready), 32'd0);
      tick;
      for (int i = 0; i < 5; i++) begin
         #4 chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("stall_result", rsp_result, 32'd30);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         tick;
      end
      rsp_ready = 2'b01;
      #4 chk("stall_hs_ready", 32'(req_ready), 32'd0);
      tick;
      rsp_ready = 2'b00;
      #4 chk("stall_grant1", 32'(req_ready), 32'h2);
      tick;
      req_valid = 2'b00;
      tick;
      #4 chk("stall_rsp1_valid", 32'(rsp_valid), 32'h2);
      chk("stall_rsp1_result", rsp_result, 32'h0F00_0F00);
      rsp_ready = 2'b10;
      tick;
      rsp_ready = 2'b00;
      // reset while executing
      set_req(1, OP_OR, 32'h0000_1234, 32'd0);
      req_valid = 2'b10;
      tick;
      req_valid = 2'b00;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_result", rsp_result, 32'd0);
      chk("arst_zero", 32'(rsp_zero), 32'd0);
      chk("arst_err", 32'(rsp_err), 32'd0);
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #4 chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
         tick;
      end
      set_req(0, OP_XOR, 32'h0000_000F, 32'h0000_0003);
      set_req(1, OP_OR, 32'h0000_0200, 32'd0);
      req_valid = 2'b11;
      #4 chk("arst_tie_grant0", 32'(req_ready), 32'h1);
      tick;
      req_valid = 2'b00;
      tick;
      #4 chk("arst_rsp_valid0", 32'(rsp_valid), 32'h1);
      chk("arst_rsp_result", rsp_result, 32'h0000_000C);
      rsp_ready = 2'b01;
      tick;
      rsp_ready = 2'b00;
      // back-to-back ties alternate from a fresh reset
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      tick;
      set_req(0, OP_ADD, 32'h0000_0100, 32'd0);
      set_req(1, OP_OR, 32'h0000_0200, 32'd0);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #4 chk("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
         tick;
         tick;
         #4 chk("rr_rsp_valid", 32'(rsp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_result", rsp_result, (i % 2 == 0) ? 32'h100 : 32'h200);
         tick;
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
